// File: rtl/regfile_pkg.sv
// regfile_pkg: shared types and fixed register indices for the register file
package regfile_pkg;
  typedef logic [4:0] reg_addr_t;
  typedef logic [31:0] word_t;
  typedef enum logic {RF_INIT, RF_RUN} rf_state_t;
  localparam int REG_ZERO = 0;
  localparam int REG_SP = 29;
endpackage

// File: rtl/rf_init_seq.sv
// rf_init_seq: post-reset sweep that loads every register with its init value, then raises ready
module rf_init_seq import regfile_pkg::*; #(
  parameter int NUM_REGS = 32,
  parameter int WIDTH = 32,
  parameter int SP_IDX = REG_SP,
  parameter word_t SP_INIT = 32'h0000_3FFC,
  localparam int AW = $clog2(NUM_REGS)
) (
  input  logic             clk,
  input  logic             rst,
  output logic             init_we,
  output logic [AW-1:0]    init_addr,
  output logic [WIDTH-1:0] init_data,
  output logic             ready
);
  rf_state_t state, state_nxt;
  logic [AW-1:0] init_cnt, cnt_nxt;
  logic last;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RF_INIT;
      init_cnt <= AW'(1);
      ready <= 1'b0;
    end else begin
      state <= state_nxt;
      init_cnt <= cnt_nxt;
      ready <= state_nxt == RF_RUN;
    end
  end
  // register 0 is never stored, so the sweep starts at 1 and stops at the last index
  always_comb begin
    last = init_cnt == AW'(NUM_REGS - 1);
    state_nxt = (state == RF_INIT && last) ? RF_RUN : state;
    cnt_nxt = (state == RF_INIT && !last) ? init_cnt + AW'(1) : init_cnt;
    init_we = state == RF_INIT && !rst;
    init_addr = init_cnt;
    init_data = (init_cnt == AW'(SP_IDX)) ? WIDTH'(SP_INIT) : '0;
  end
endmodule

// File: rtl/reg_file_wb.sv
// reg_file_wb: MIPS register file with init sweep, r0 hardwired to zero and optional write-first forwarding
module reg_file_wb import regfile_pkg::*; #(
  parameter int NUM_REGS = 32,
  parameter int WIDTH = 32,
  parameter int SP_IDX = REG_SP,
  parameter word_t SP_INIT = 32'h0000_3FFC,
  parameter int BYPASS = 1,
  localparam int AW = $clog2(NUM_REGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             reg_write,
  input  logic [AW-1:0]    write_reg,
  input  logic [WIDTH-1:0] write_data,
  input  logic [AW-1:0]    read_reg1,
  input  logic [AW-1:0]    read_reg2,
  output logic [WIDTH-1:0] read_data1,
  output logic [WIDTH-1:0] read_data2,
  output logic             ready
);
  logic [WIDTH-1:0] regs [NUM_REGS];
  logic init_we, port_we, hit1, hit2;
  logic [AW-1:0] init_addr;
  logic [WIDTH-1:0] init_data;
  rf_init_seq #(
    .NUM_REGS(NUM_REGS),
    .WIDTH(WIDTH),
    .SP_IDX(SP_IDX),
    .SP_INIT(SP_INIT)
  ) u_seq (
    .clk(clk),
    .rst(rst),
    .init_we(init_we),
    .init_addr(init_addr),
    .init_data(init_data),
    .ready(ready)
  );
  assign port_we = ready && !rst && reg_write && write_reg != AW'(REG_ZERO);
  always_ff @(posedge clk) begin
    if (init_we) regs[init_addr] <= init_data;
    else if (port_we) regs[write_reg] <= write_data;
  end
  assign hit1 = BYPASS != 0 && reg_write && write_reg == read_reg1;
  assign hit2 = BYPASS != 0 && reg_write && write_reg == read_reg2;
  // operands are forced to zero until the sweep has finished so no stale or X data leaks out
  assign read_data1 = (!ready || read_reg1 == AW'(REG_ZERO)) ? '0 : hit1 ? write_data : regs[read_reg1];
  assign read_data2 = (!ready || read_reg2 == AW'(REG_ZERO)) ? '0 : hit2 ? write_data : regs[read_reg2];
endmodule
